// File: rtl/debounce_pkg.sv
// Shared constants and per-channel output bundle for the input debounce bank.
package debounce_pkg;
    localparam int EDGE_RISE   = 0;
    localparam int EDGE_FALL   = 1;
    localparam int EDGE_BOTH   = 2;
    localparam int SYNC_STAGES = 2;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } ch_out_t;

    function automatic logic sel_edge(input int mode, input logic rise, input logic fall);
        case (mode)
            EDGE_RISE: sel_edge = rise;
            EDGE_FALL: sel_edge = fall;
            default:   sel_edge = rise | fall;
        endcase
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-FF synchronizer, stability counter, stable level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   CNT_W       = 20,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] eff_dt_i,
    input  logic             sig_i,
    output ch_out_t          out_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s2;
    logic [CNT_W:0]         cnt_inc;

    assign s2      = sync_q[SYNC_STAGES-1];
    // one bit wider so the compare is safe even after delaytime drops below cnt
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2 != level_q) begin
            if (cnt_inc >= {1'b0, eff_dt_i}) begin
                level_d = s2;
                rise_d  = s2;
                fall_d  = ~s2;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out_o = '{level: level_q, rise: rise_q, fall: fall_q};
endmodule

// File: rtl/input_debounce_bank.sv
// N-channel debounce/edge-detect bank. Define DEBOUNCE_IRQ_EN to build the sticky
// edge-capture register and its masked, registered IRQ output.
module input_debounce_bank
    import debounce_pkg::*;
#(
    parameter int   N_CH        = 8,
    parameter int   CNT_W       = 20,
    parameter logic RESET_LEVEL = 1'b1,
    parameter int   EDGE_MODE   = EDGE_BOTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] delaytime_i,
    input  logic [N_CH-1:0]  signal_in_i,
    output logic [N_CH-1:0]  signal_out_o,
    output logic [N_CH-1:0]  rise_pulse_o,
    output logic [N_CH-1:0]  fall_pulse_o,
    output logic [N_CH-1:0]  edge_capture_o,
    input  logic [N_CH-1:0]  edge_clr_i,
    input  logic [N_CH-1:0]  irq_mask_i,
    output logic             irq_o
);
    logic [CNT_W-1:0] eff_dt;
    ch_out_t          ch_out [N_CH];

    assign eff_dt = (delaytime_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : delaytime_i;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .CNT_W       (CNT_W),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .eff_dt_i (eff_dt),
            .sig_i    (signal_in_i[g]),
            .out_o    (ch_out[g])
        );
        assign signal_out_o[g] = ch_out[g].level;
        assign rise_pulse_o[g] = ch_out[g].rise;
        assign fall_pulse_o[g] = ch_out[g].fall;
    end

`ifdef DEBOUNCE_IRQ_EN
    logic [N_CH-1:0] cap_q, cap_d;
    logic            irq_q, irq_d;

    // a new edge in the same cycle as its clear keeps the flag set
    always_comb begin
        cap_d = cap_q & ~edge_clr_i;
        for (int i = 0; i < N_CH; i++) begin
            cap_d[i] = cap_d[i] | sel_edge(EDGE_MODE, ch_out[i].rise, ch_out[i].fall);
        end
        irq_d = |(cap_q & irq_mask_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            irq_q <= irq_d;
        end
    end

    assign edge_capture_o = cap_q;
    assign irq_o          = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{edge_clr_i, irq_mask_i} ^ (EDGE_MODE == EDGE_BOTH);
    assign edge_capture_o    = '0;
    assign irq_o             = 1'b0;
`endif
endmodule

// File: tb/tb_input_debounce_bank.sv
// Self-checking bench for input_debounce_bank: directed scenarios plus randomized traffic
// against a run-length reference model. The max-delay boundary uses a 12-bit counter.
module tb_input_debounce_bank;
    localparam int   N    = 8;
    localparam int   CW   = 12;
    localparam logic RL   = 1'b1;
    localparam int   MODE = 2;
`ifdef DEBOUNCE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] delaytime;
    logic [N-1:0]  signal_in, signal_out, rise_pulse, fall_pulse, edge_capture, edge_clr, irq_mask;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_cap;
    logic         m_irq;
    int           m_run [N];

    always #5 clk = ~clk;

    input_debounce_bank #(.N_CH(N), .CNT_W(CW), .RESET_LEVEL(RL), .EDGE_MODE(MODE)) dut (
        .clk_i(clk), .rst_i(rst), .delaytime_i(delaytime), .signal_in_i(signal_in),
        .signal_out_o(signal_out), .rise_pulse_o(rise_pulse), .fall_pulse_o(fall_pulse),
        .edge_capture_o(edge_capture), .edge_clr_i(edge_clr), .irq_mask_i(irq_mask), .irq_o(irq)
    );

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        logic [N-1:0]  in_s, clr_s, mask_s, sel, n_cap;
        logic [CW-1:0] dt_s;
        logic          rst_s, n_irq;
        int            eff;
        in_s = signal_in; clr_s = edge_clr; mask_s = irq_mask; dt_s = delaytime; rst_s = rst;
        @(posedge clk);
        #1;
        if (rst_s) begin
            m_s1 = {N{RL}}; m_s2 = {N{RL}}; m_out = {N{RL}};
            m_rise = '0; m_fall = '0; m_cap = '0; m_irq = 1'b0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            sel   = (MODE == 0) ? m_rise : (MODE == 1) ? m_fall : (m_rise | m_fall);
            n_cap = IRQ_ON ? ((m_cap & ~clr_s) | sel) : '0;
            n_irq = IRQ_ON ? |(m_cap & mask_s) : 1'b0;
            eff   = (dt_s == 0) ? 1 : int'(dt_s);
            for (int c = 0; c < N; c++) begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (m_s2[c] == m_out[c]) begin
                    m_run[c] = 0;
                end else if (m_run[c] + 1 >= eff) begin
                    // held different for eff consecutive edges: accept the new level
                    m_out[c]  = m_s2[c];
                    m_rise[c] = m_s2[c];
                    m_fall[c] = ~m_s2[c];
                    m_run[c]  = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                end
            end
            m_s2 = m_s1; m_s1 = in_s; m_cap = n_cap; m_irq = n_irq;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; signal_in = '1; delaytime = 10; edge_clr = '0; irq_mask = '0;
        repeat (3) tick();
        n_tests++;
        if (signal_out !== 8'hFF) begin n_fail++; $display("FAIL reset_out: got %h want ff", signal_out); end
        n_tests++;
        if ((rise_pulse | fall_pulse) !== 8'h00) begin n_fail++; $display("FAIL reset_pulses: got r=%h f=%h want 00", rise_pulse, fall_pulse); end
        n_tests++;
        if (edge_capture !== 8'h00 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got cap=%h irq=%b want 00/0", edge_capture, irq); end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (signal_out !== 8'hFF || (rise_pulse | fall_pulse) !== 8'h00) begin
                n_fail++; $display("FAIL reset_hold: got out=%h r=%h f=%h want ff/00/00", signal_out, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_step();
        logic el, ef;
        delaytime = 10; signal_in[0] = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            el = (k >= 12) ? 1'b0 : 1'b1;
            ef = (k == 12);
            n_tests++;
            if (signal_out[0] !== el || fall_pulse[0] !== ef || rise_pulse[0] !== 1'b0) begin
                n_fail++; $display("FAIL step edge %0d: got out=%b fall=%b rise=%b want out=%b fall=%b rise=0", k, signal_out[0], fall_pulse[0], rise_pulse[0], el, ef);
            end
        end
        signal_in[0] = 1'b1;
        repeat (15) tick();
    endtask

    task automatic test_glitch();
        delaytime = 10; signal_in[3] = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (k == 9) signal_in[3] = 1'b1;
            n_tests++;
            if (signal_out[3] !== 1'b1 || fall_pulse[3] !== 1'b0) begin
                n_fail++; $display("FAIL glitch9 edge %0d: got out=%b fall=%b want 1/0", k, signal_out[3], fall_pulse[3]);
            end
        end
        signal_in[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) signal_in[3] = 1'b1;
            n_tests++;
            if (signal_out[3] !== (k < 12) || fall_pulse[3] !== (k == 12)) begin
                n_fail++; $display("FAIL glitch10 edge %0d: got out=%b fall=%b want %b/%b", k, signal_out[3], fall_pulse[3], k < 12, k == 12);
            end
        end
        repeat (15) tick();
        n_tests++;
        if (signal_out !== 8'hFF) begin n_fail++; $display("FAIL glitch_recover: got %h want ff", signal_out); end
    endtask

    task automatic test_dt_limits();
        for (int d = 0; d <= 1; d++) begin
            delaytime = CW'(d); signal_in[1] = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                tick();
                n_tests++;
                if (signal_out[1] !== (k < 3) || fall_pulse[1] !== (k == 3)) begin
                    n_fail++; $display("FAIL dt%0d edge %0d: got out=%b fall=%b want %b/%b", d, k, signal_out[1], fall_pulse[1], k < 3, k == 3);
                end
            end
            signal_in[1] = 1'b1;
            repeat (6) tick();
        end
        delaytime = '1; signal_in[2] = 1'b0;
        repeat ((1 << CW)) tick();
        n_tests++;
        if (signal_out[2] !== 1'b1) begin n_fail++; $display("FAIL dtmax_early: got %b want 1", signal_out[2]); end
        tick();
        n_tests++;
        if (signal_out[2] !== 1'b0 || fall_pulse[2] !== 1'b1) begin
            n_fail++; $display("FAIL dtmax_commit: got out=%b fall=%b want 0/1", signal_out[2], fall_pulse[2]);
        end
        signal_in[2] = 1'b1; delaytime = 1;
        repeat (5) tick();
        // lowering delaytime below the running count commits on the next edge
        delaytime = 10; signal_in[2] = 1'b0;
        repeat (8) tick();
        n_tests++;
        if (signal_out[2] !== 1'b1) begin n_fail++; $display("FAIL dt_lower_pre: got %b want 1", signal_out[2]); end
        delaytime = 4;
        tick();
        n_tests++;
        if (signal_out[2] !== 1'b0 || fall_pulse[2] !== 1'b1) begin
            n_fail++; $display("FAIL dt_lower_commit: got out=%b fall=%b want 0/1", signal_out[2], fall_pulse[2]);
        end
        signal_in[2] = 1'b1; delaytime = 1;
        repeat (5) tick();
    endtask

    task automatic test_irq();
        delaytime = 2; irq_mask = 8'h01; edge_clr = '1;
        repeat (2) tick();
        edge_clr = '0;
        n_tests++;
        if (edge_capture !== 8'h00 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear_all: got cap=%h irq=%b want 00/0", edge_capture, irq); end
        signal_in[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_tests++;
            if (fall_pulse[0] !== (k == 4) || edge_capture[0] !== (IRQ_ON && k >= 5) || irq !== (IRQ_ON && k >= 6)) begin
                n_fail++; $display("FAIL irq_set edge %0d: got fall=%b cap=%b irq=%b want %b/%b/%b", k, fall_pulse[0], edge_capture[0], irq, k == 4, IRQ_ON && k >= 5, IRQ_ON && k >= 6);
            end
        end
        signal_in[0] = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (rise_pulse[0] !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", rise_pulse[0]); end
        edge_clr = 8'h01;
        tick();
        n_tests++;
        if (edge_capture[0] !== IRQ_ON) begin n_fail++; $display("FAIL irq_set_wins: got %b want %b", edge_capture[0], IRQ_ON); end
        tick();
        n_tests++;
        if (edge_capture[0] !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b want 0", edge_capture[0]); end
        tick();
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b want 0", irq); end
        edge_clr = '0;
    endtask

    task automatic test_simultaneous();
        delaytime = 5; signal_in = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (signal_out !== ((k < 7) ? 8'hFF : 8'h00) || fall_pulse !== ((k == 7) ? 8'hFF : 8'h00) || rise_pulse !== 8'h00) begin
                n_fail++; $display("FAIL simul edge %0d: got out=%h fall=%h rise=%h", k, signal_out, fall_pulse, rise_pulse);
            end
        end
        signal_in = 8'hFF;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (signal_out !== 8'hFF || (rise_pulse | fall_pulse) !== 8'h00 || edge_capture !== 8'h00 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midrst: got out=%h r=%h f=%h cap=%h irq=%b want ff/00/00/00/0", signal_out, rise_pulse, fall_pulse, edge_capture, irq);
        end
        signal_in = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_tests++;
            if (signal_out !== ((k < 7) ? 8'hFF : 8'h00)) begin
                n_fail++; $display("FAIL postrst edge %0d: got %h want %h", k, signal_out, (k < 7) ? 8'hFF : 8'h00);
            end
        end
        signal_in = 8'hFF;
        repeat (10) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) delaytime = CW'($urandom_range(0, 6));
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 7) == 0) signal_in[c] = ~signal_in[c];
            irq_mask = N'($urandom);
            edge_clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            rst      = ($urandom_range(0, 499) == 0);
            tick();
            n_tests++;
            if (signal_out !== m_out || rise_pulse !== m_rise || fall_pulse !== m_fall || edge_capture !== m_cap || irq !== m_irq) begin
                n_fail++;
                $display("FAIL random cyc %0d: got out=%h r=%h f=%h cap=%h irq=%b want %h/%h/%h/%h/%b",
                         k, signal_out, rise_pulse, fall_pulse, edge_capture, irq, m_out, m_rise, m_fall, m_cap, m_irq);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_dt_limits();
        test_irq();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
